// File: rtl/ingress_pkt_writer_if.sv
// Bundles the ingress word stream, memory port A, the descriptor channel and
// the release channel of the ingress packet writer.
interface ingress_pkt_writer_if #(
  parameter int MEM_SIZE      = 512,
  parameter int DATA_WIDTH    = 20,
  parameter int MAX_PKT_WORDS = 64
);
  localparam int ADDR_W = $clog2(MEM_SIZE);
  localparam int LEN_W  = $clog2(MAX_PKT_WORDS) + 1;
  localparam int FREE_W = $clog2(MEM_SIZE) + 1;

  logic                  in_valid;
  logic                  in_sop;
  logic                  in_eop;
  logic [DATA_WIDTH-1:0] in_data;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  desc_valid;
  logic                  desc_ready;
  logic [ADDR_W-1:0]     desc_addr;
  logic [LEN_W-1:0]      desc_len;
  logic                  rel_valid;
  logic [LEN_W-1:0]      rel_len;
  logic [FREE_W-1:0]     free_words;
  logic [15:0]           drop_cnt;

  modport master (
    output in_valid, in_sop, in_eop, in_data, desc_ready, rel_valid, rel_len,
    input  mem_addr, mem_wdata, mem_we, desc_valid, desc_addr, desc_len,
           free_words, drop_cnt
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_data, desc_ready, rel_valid, rel_len,
    output mem_addr, mem_wdata, mem_we, desc_valid, desc_addr, desc_len,
           free_words, drop_cnt
  );
endinterface

// File: rtl/ingress_pkt_writer.sv
// Writes admitted ingress packets into a circular region of the packet memory,
// emits one (start, length) descriptor per packet and drops what cannot be stored.
module ingress_pkt_writer #(
  parameter int MEM_SIZE      = 512,
  parameter int DATA_WIDTH    = 20,
  parameter int MAX_PKT_WORDS = 64,
  parameter int DESC_DEPTH    = 8
) (
  input logic                clk,
  input logic                rst_n,
  ingress_pkt_writer_if.slave bus
);
  localparam int ADDR_W = $clog2(MEM_SIZE);
  localparam int LEN_W  = $clog2(MAX_PKT_WORDS) + 1;
  localparam int FREE_W = $clog2(MEM_SIZE) + 1;
  localparam int SUM_W  = FREE_W + 2;
  localparam int DPTR_W = $clog2(DESC_DEPTH);
  localparam int DCNT_W = DPTR_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

  state_t                state, state_next;
  logic [ADDR_W-1:0]     wr_ptr, wr_ptr_next, pkt_start, pkt_start_next, base_ptr;
  logic [LEN_W-1:0]      len, len_next;
  logic [FREE_W-1:0]     free_words, free_next;
  logic [SUM_W-1:0]      free_eff, free_sum;
  logic [15:0]           drop_cnt, drop_next;
  logic [16:0]           drop_sum;
  logic [1:0]            drop_inc;
  logic                  write, rollback, eval_sop, admit, push, fifo_full, pop;

  logic                  mem_we_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic                  push_valid;
  logic [ADDR_W-1:0]     push_addr;
  logic [LEN_W-1:0]      push_len;
  logic [ADDR_W-1:0]     desc_addr_mem [DESC_DEPTH];
  logic [LEN_W-1:0]      desc_len_mem  [DESC_DEPTH];
  logic [DPTR_W-1:0]     rd_ptr, wr_idx;
  logic [DCNT_W-1:0]     desc_count;

  // A pending push counts as occupied so an admitted packet always finds a slot.
  assign fifo_full = ((DCNT_W+1)'(desc_count) + (DCNT_W+1)'(push_valid)) >= (DCNT_W+1)'(DESC_DEPTH);
  assign pop       = (desc_count != '0) && bus.desc_ready;

  always_comb begin
    state_next     = state;
    len_next       = len;
    pkt_start_next = pkt_start;
    write          = 1'b0;
    rollback       = 1'b0;
    eval_sop       = 1'b0;
    push           = 1'b0;
    drop_inc       = 2'd0;

    if (bus.in_valid) begin
      case (state)
        WRITE: begin
          if (bus.in_sop) begin
            rollback = 1'b1;
            drop_inc = 2'd1;
            eval_sop = 1'b1;
          end else if (len == LEN_W'(MAX_PKT_WORDS)) begin
            rollback   = 1'b1;
            drop_inc   = 2'd1;
            state_next = bus.in_eop ? IDLE : DROP;
          end else begin
            write    = 1'b1;
            len_next = len + 1'b1;
            if (bus.in_eop) begin
              push       = 1'b1;
              state_next = IDLE;
            end
          end
        end
        DROP: begin
          if (bus.in_sop) begin
            eval_sop = 1'b1;
          end else if (bus.in_eop) begin
            state_next = IDLE;
          end
        end
        default: eval_sop = bus.in_sop;
      endcase
    end

    // A rolled-back packet gives its words back before the new sop is judged.
    base_ptr = rollback ? pkt_start : wr_ptr;
    free_eff = SUM_W'(free_words) + (rollback ? SUM_W'(len) : SUM_W'(0));
    admit    = (free_eff >= SUM_W'(MAX_PKT_WORDS)) && !fifo_full;

    if (eval_sop) begin
      if (admit) begin
        write          = 1'b1;
        pkt_start_next = base_ptr;
        len_next       = LEN_W'(1);
        push           = bus.in_eop;
        state_next     = bus.in_eop ? IDLE : WRITE;
      end else begin
        drop_inc   = drop_inc + 2'd1;
        state_next = bus.in_eop ? IDLE : DROP;
      end
    end

    wr_ptr_next = base_ptr + ADDR_W'(write);
    free_sum    = SUM_W'(free_words)
                + (bus.rel_valid ? SUM_W'(bus.rel_len) : SUM_W'(0))
                + (rollback ? SUM_W'(len) : SUM_W'(0))
                - SUM_W'(write);
    free_next   = (free_sum > SUM_W'(MEM_SIZE)) ? FREE_W'(MEM_SIZE) : free_sum[FREE_W-1:0];
    drop_sum    = {1'b0, drop_cnt} + 17'(drop_inc);
    drop_next   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      pkt_start   <= '0;
      len         <= '0;
      free_words  <= FREE_W'(MEM_SIZE);
      drop_cnt    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      push_valid  <= 1'b0;
      push_addr   <= '0;
      push_len    <= '0;
    end else begin
      state      <= state_next;
      wr_ptr     <= wr_ptr_next;
      pkt_start  <= pkt_start_next;
      len        <= len_next;
      free_words <= free_next;
      drop_cnt   <= drop_next;
      mem_we_q   <= write;
      if (write) begin
        mem_addr_q  <= base_ptr;
        mem_wdata_q <= bus.in_data;
      end
      push_valid <= push;
      push_addr  <= pkt_start_next;
      push_len   <= len_next;
    end
  end

  // The push is delayed one cycle so the descriptor trails the last memory write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DESC_DEPTH; i++) begin
        desc_addr_mem[i] <= '0;
        desc_len_mem[i]  <= '0;
      end
      rd_ptr     <= '0;
      wr_idx     <= '0;
      desc_count <= '0;
    end else begin
      if (push_valid) begin
        desc_addr_mem[wr_idx] <= push_addr;
        desc_len_mem[wr_idx]  <= push_len;
        wr_idx                <= wr_idx + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_valid && !pop) begin
        desc_count <= desc_count + 1'b1;
      end else if (!push_valid && pop) begin
        desc_count <= desc_count - 1'b1;
      end
    end
  end

  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.desc_valid = (desc_count != '0);
  assign bus.desc_addr  = desc_addr_mem[rd_ptr];
  assign bus.desc_len   = desc_len_mem[rd_ptr];
  assign bus.free_words = free_words;
  assign bus.drop_cnt   = drop_cnt;

endmodule

// File: tb/tb_ingress_pkt_writer.sv
// Directed bench for ingress_pkt_writer: framing, wrap, drops, rollback,
// space accounting, descriptor FIFO limits and mid-packet reset.
module tb_ingress_pkt_writer;
  localparam int MEM_SIZE      = 512;
  localparam int DATA_WIDTH    = 20;
  localparam int MAX_PKT_WORDS = 64;
  localparam int DESC_DEPTH    = 8;
  localparam int ADDR_W        = $clog2(MEM_SIZE);
  localparam int LEN_W         = $clog2(MAX_PKT_WORDS) + 1;
  localparam int FREE_W        = $clog2(MEM_SIZE) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  ingress_pkt_writer_if #(
    .MEM_SIZE(MEM_SIZE), .DATA_WIDTH(DATA_WIDTH), .MAX_PKT_WORDS(MAX_PKT_WORDS)
  ) bus ();

  ingress_pkt_writer #(
    .MEM_SIZE(MEM_SIZE), .DATA_WIDTH(DATA_WIDTH),
    .MAX_PKT_WORDS(MAX_PKT_WORDS), .DESC_DEPTH(DESC_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Drives one word for one clock; outputs are sampled 1 time unit after the edge.
  task automatic send_word(input logic sop, input logic eop, input logic [DATA_WIDTH-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_sop   = sop;
    bus.in_eop   = eop;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  task automatic send_idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_rel(input int n);
    bus.rel_valid = 1'b1;
    bus.rel_len   = LEN_W'(n);
    @(posedge clk);
    #1;
    bus.rel_valid = 1'b0;
  endtask

  task automatic send_pkt(input int n);
    for (int i = 0; i < n; i++) send_word(i == 0, i == n - 1, DATA_WIDTH'(32'h55000 + i));
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_sop     = 1'b0;
    bus.in_eop     = 1'b0;
    bus.in_data    = '0;
    bus.desc_ready = 1'b0;
    bus.rel_valid  = 1'b0;
    bus.rel_len    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    compared++; if (bus.mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_we: got %0b expected 0", bus.mem_we); end
    compared++; if (bus.mem_addr !== '0) begin mismatched++; $display("[TB] FAIL reset_mem_addr: got %0d expected 0", bus.mem_addr); end
    compared++; if (bus.mem_wdata !== '0) begin mismatched++; $display("[TB] FAIL reset_mem_wdata: got %0h expected 0", bus.mem_wdata); end
    compared++; if (bus.desc_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_desc_valid: got %0b expected 0", bus.desc_valid); end
    compared++; if (bus.desc_addr !== '0) begin mismatched++; $display("[TB] FAIL reset_desc_addr: got %0d expected 0", bus.desc_addr); end
    compared++; if (bus.desc_len !== '0) begin mismatched++; $display("[TB] FAIL reset_desc_len: got %0d expected 0", bus.desc_len); end
    compared++; if (bus.free_words !== FREE_W'(512)) begin mismatched++; $display("[TB] FAIL reset_free: got %0d expected 512", bus.free_words); end
    compared++; if (bus.drop_cnt !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_drop: got %0d expected 0", bus.drop_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_packet();
    for (int i = 0; i < 4; i++) begin
      send_word(i == 0, i == 3, DATA_WIDTH'(32'hA0000 + i));
      compared++; if (bus.mem_we !== 1'b1) begin mismatched++; $display("[TB] FAIL single_we[%0d]: got %0b expected 1", i, bus.mem_we); end
      compared++; if (bus.mem_addr !== ADDR_W'(i)) begin mismatched++; $display("[TB] FAIL single_addr[%0d]: got %0d expected %0d", i, bus.mem_addr, i); end
      compared++; if (bus.mem_wdata !== DATA_WIDTH'(32'hA0000 + i)) begin mismatched++; $display("[TB] FAIL single_data[%0d]: got %0h expected %0h", i, bus.mem_wdata, 32'hA0000 + i); end
    end
    compared++; if (bus.desc_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_desc_early: got %0b expected 0", bus.desc_valid); end
    compared++; if (bus.free_words !== FREE_W'(508)) begin mismatched++; $display("[TB] FAIL single_free: got %0d expected 508", bus.free_words); end
    send_idle(1);
    compared++; if (bus.mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL single_we_idle: got %0b expected 0", bus.mem_we); end
    compared++; if (bus.desc_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL single_desc_valid: got %0b expected 1", bus.desc_valid); end
    compared++; if (bus.desc_addr !== ADDR_W'(0)) begin mismatched++; $display("[TB] FAIL single_desc_addr: got %0d expected 0", bus.desc_addr); end
    compared++; if (bus.desc_len !== LEN_W'(4)) begin mismatched++; $display("[TB] FAIL single_desc_len: got %0d expected 4", bus.desc_len); end
    bus.desc_ready = 1'b1;
    send_idle(1);
    bus.desc_ready = 1'b0;
    compared++; if (bus.desc_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_desc_pop: got %0b expected 0", bus.desc_valid); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_addr [4];
    exp_addr = '{ADDR_W'(510), ADDR_W'(511), ADDR_W'(0), ADDR_W'(1)};
    send_rel(4);
    compared++; if (bus.free_words !== FREE_W'(512)) begin mismatched++; $display("[TB] FAIL wrap_free_start: got %0d expected 512", bus.free_words); end
    // 4 + 7*64 + 58 words moves the write pointer to 510.
    bus.desc_ready = 1'b1;
    for (int p = 0; p < 7; p++) begin
      send_pkt(64);
      send_rel(64);
    end
    send_pkt(58);
    send_rel(58);
    send_idle(2);
    bus.desc_ready = 1'b0;
    compared++; if (bus.free_words !== FREE_W'(512)) begin mismatched++; $display("[TB] FAIL wrap_free_pre: got %0d expected 512", bus.free_words); end
    for (int i = 0; i < 4; i++) begin
      send_word(i == 0, i == 3, DATA_WIDTH'(32'hB0000 + i));
      compared++; if (bus.mem_we !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_we[%0d]: got %0b expected 1", i, bus.mem_we); end
      compared++; if (bus.mem_addr !== exp_addr[i]) begin mismatched++; $display("[TB] FAIL wrap_addr[%0d]: got %0d expected %0d", i, bus.mem_addr, exp_addr[i]); end
    end
    send_idle(1);
    compared++; if (bus.desc_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_desc_valid: got %0b expected 1", bus.desc_valid); end
    compared++; if (bus.desc_addr !== ADDR_W'(510)) begin mismatched++; $display("[TB] FAIL wrap_desc_addr: got %0d expected 510", bus.desc_addr); end
    compared++; if (bus.desc_len !== LEN_W'(4)) begin mismatched++; $display("[TB] FAIL wrap_desc_len: got %0d expected 4", bus.desc_len); end
    bus.desc_ready = 1'b1;
    send_rel(4);
    bus.desc_ready = 1'b0;
    compared++; if (bus.free_words !== FREE_W'(512)) begin mismatched++; $display("[TB] FAIL wrap_free_end: got %0d expected 512", bus.free_words); end
  endtask

  task automatic test_full_drop();
    int we_seen;
    bus.desc_ready = 1'b1;
    for (int p = 0; p < 8; p++) send_pkt(64);
    compared++; if (bus.free_words !== FREE_W'(0)) begin mismatched++; $display("[TB] FAIL full_free_zero: got %0d expected 0", bus.free_words); end
    we_seen = 0;
    for (int i = 0; i < 10; i++) begin
      send_word(i == 0, i == 9, DATA_WIDTH'(32'hC0000 + i));
      if (bus.mem_we === 1'b1) we_seen++;
    end
    compared++; if (we_seen !== 0) begin mismatched++; $display("[TB] FAIL full_no_write: got %0d writes expected 0", we_seen); end
    compared++; if (bus.drop_cnt !== 16'd1) begin mismatched++; $display("[TB] FAIL full_drop_cnt: got %0d expected 1", bus.drop_cnt); end
    send_rel(64);
    compared++; if (bus.free_words !== FREE_W'(64)) begin mismatched++; $display("[TB] FAIL full_free_rel: got %0d expected 64", bus.free_words); end
    for (int i = 0; i < 2; i++) begin
      send_word(i == 0, i == 1, DATA_WIDTH'(32'hC1000 + i));
      compared++; if (bus.mem_we !== 1'b1) begin mismatched++; $display("[TB] FAIL full_after_we[%0d]: got %0b expected 1", i, bus.mem_we); end
      compared++; if (bus.mem_addr !== ADDR_W'(2 + i)) begin mismatched++; $display("[TB] FAIL full_after_addr[%0d]: got %0d expected %0d", i, bus.mem_addr, 2 + i); end
    end
    compared++; if (bus.free_words !== FREE_W'(62)) begin mismatched++; $display("[TB] FAIL full_free_62: got %0d expected 62", bus.free_words); end
    for (int p = 0; p < 7; p++) send_rel(64);
    send_rel(2);
    compared++; if (bus.free_words !== FREE_W'(512)) begin mismatched++; $display("[TB] FAIL full_free_back: got %0d expected 512", bus.free_words); end
    send_rel(64);
    compared++; if (bus.free_words !== FREE_W'(512)) begin mismatched++; $display("[TB] FAIL full_free_clamp: got %0d expected 512", bus.free_words); end
    send_idle(2);
    bus.desc_ready = 1'b0;
  endtask

  task automatic test_oversize();
    do_reset();
    bus.desc_ready = 1'b1;
    send_pkt(3);
    send_idle(2);
    send_rel(3);
    for (int i = 0; i < 65; i++) begin
      send_word(i == 0, i == 64, DATA_WIDTH'(32'hD0000 + i));
      if (i < 64) begin
        compared++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== ADDR_W'(3 + i)) begin mismatched++; $display("[TB] FAIL over_write[%0d]: got we=%0b addr=%0d expected we=1 addr=%0d", i, bus.mem_we, bus.mem_addr, 3 + i); end
      end
      if (i == 63) begin
        compared++; if (bus.free_words !== FREE_W'(448)) begin mismatched++; $display("[TB] FAIL over_free_mid: got %0d expected 448", bus.free_words); end
      end
    end
    compared++; if (bus.mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL over_65th_we: got %0b expected 0", bus.mem_we); end
    compared++; if (bus.free_words !== FREE_W'(512)) begin mismatched++; $display("[TB] FAIL over_free_restore: got %0d expected 512", bus.free_words); end
    compared++; if (bus.drop_cnt !== 16'd1) begin mismatched++; $display("[TB] FAIL over_drop_cnt: got %0d expected 1", bus.drop_cnt); end
    send_idle(3);
    compared++; if (bus.desc_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL over_no_desc: got %0b expected 0", bus.desc_valid); end
    bus.desc_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      send_word(i == 0, i == 1, DATA_WIDTH'(32'hD1000 + i));
      compared++; if (bus.mem_addr !== ADDR_W'(3 + i)) begin mismatched++; $display("[TB] FAIL over_next_addr[%0d]: got %0d expected %0d", i, bus.mem_addr, 3 + i); end
    end
    send_idle(1);
    compared++; if (bus.desc_addr !== ADDR_W'(3) || bus.desc_len !== LEN_W'(2)) begin mismatched++; $display("[TB] FAIL over_next_desc: got addr=%0d len=%0d expected addr=3 len=2", bus.desc_addr, bus.desc_len); end
  endtask

  task automatic test_simultaneous();
    logic we_x;
    bus.desc_ready = 1'b1;
    send_pkt(64);
    send_word(1'b1, 1'b0, DATA_WIDTH'(32'hE0000));
    compared++; if (bus.free_words !== FREE_W'(445)) begin mismatched++; $display("[TB] FAIL sim_free_before: got %0d expected 445", bus.free_words); end
    bus.rel_valid = 1'b1;
    bus.rel_len   = LEN_W'(5);
    send_word(1'b0, 1'b0, DATA_WIDTH'(32'hE0001));
    bus.rel_valid = 1'b0;
    compared++; if (bus.free_words !== FREE_W'(449)) begin mismatched++; $display("[TB] FAIL sim_free_net: got %0d expected 449", bus.free_words); end
    send_word(1'b0, 1'b1, DATA_WIDTH'(32'hE0002));
    send_idle(3);
    bus.desc_ready = 1'b0;
    // Eight single-word packets fill the descriptor FIFO; the ninth must drop.
    for (int k = 0; k < 8; k++) begin
      send_word(1'b1, 1'b1, DATA_WIDTH'(32'hE1000 + k));
      compared++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== ADDR_W'(72 + k)) begin mismatched++; $display("[TB] FAIL sim_single[%0d]: got we=%0b addr=%0d expected we=1 addr=%0d", k, bus.mem_we, bus.mem_addr, 72 + k); end
    end
    send_word(1'b1, 1'b1, DATA_WIDTH'(32'hE1FFF));
    compared++; if (bus.mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL sim_full_we: got %0b expected 0", bus.mem_we); end
    compared++; if (bus.drop_cnt !== 16'd2) begin mismatched++; $display("[TB] FAIL sim_full_drop: got %0d expected 2", bus.drop_cnt); end
    compared++; if (bus.desc_addr !== ADDR_W'(72)) begin mismatched++; $display("[TB] FAIL sim_head: got %0d expected 72", bus.desc_addr); end
    bus.desc_ready = 1'b1;
    send_idle(1);
    bus.desc_ready = 1'b0;
    send_word(1'b1, 1'b1, DATA_WIDTH'(32'hE2000));
    we_x = bus.mem_we;
    compared++; if (we_x !== 1'b1 || bus.mem_addr !== ADDR_W'(80)) begin mismatched++; $display("[TB] FAIL sim_x_write: got we=%0b addr=%0d expected we=1 addr=80", we_x, bus.mem_addr); end
    bus.desc_ready = 1'b1;
    send_idle(1);
    bus.desc_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      compared++; if (bus.desc_valid !== 1'b1 || bus.desc_addr !== ADDR_W'(74 + k) || bus.desc_len !== LEN_W'(1)) begin mismatched++; $display("[TB] FAIL sim_drain[%0d]: got v=%0b addr=%0d len=%0d expected v=1 addr=%0d len=1", k, bus.desc_valid, bus.desc_addr, bus.desc_len, 74 + k); end
      bus.desc_ready = 1'b1;
      send_idle(1);
      bus.desc_ready = 1'b0;
    end
    compared++; if (bus.desc_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL sim_drained: got %0b expected 0", bus.desc_valid); end
    compared++; if (bus.free_words !== FREE_W'(439)) begin mismatched++; $display("[TB] FAIL sim_free_end: got %0d expected 439", bus.free_words); end
  endtask

  task automatic test_reset_mid();
    send_word(1'b1, 1'b1, DATA_WIDTH'(32'hF0000));
    send_idle(2);
    send_word(1'b1, 1'b0, DATA_WIDTH'(32'hF1000));
    send_word(1'b0, 1'b0, DATA_WIDTH'(32'hF1001));
    rst_n = 1'b0;
    #1;
    compared++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin mismatched++; $display("[TB] FAIL mid_mem: got we=%0b addr=%0d data=%0h expected 0/0/0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    compared++; if (bus.desc_valid !== 1'b0 || bus.desc_addr !== '0 || bus.desc_len !== '0) begin mismatched++; $display("[TB] FAIL mid_desc: got v=%0b addr=%0d len=%0d expected 0/0/0", bus.desc_valid, bus.desc_addr, bus.desc_len); end
    compared++; if (bus.free_words !== FREE_W'(512) || bus.drop_cnt !== 16'd0) begin mismatched++; $display("[TB] FAIL mid_counts: got free=%0d drop=%0d expected 512/0", bus.free_words, bus.drop_cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_idle(3);
    compared++; if (bus.desc_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_no_desc: got %0b expected 0", bus.desc_valid); end
    for (int i = 0; i < 2; i++) begin
      send_word(i == 0, i == 1, DATA_WIDTH'(32'hF2000 + i));
      compared++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== ADDR_W'(i)) begin mismatched++; $display("[TB] FAIL mid_next[%0d]: got we=%0b addr=%0d expected we=1 addr=%0d", i, bus.mem_we, bus.mem_addr, i); end
    end
    send_idle(1);
    compared++; if (bus.desc_addr !== ADDR_W'(0) || bus.desc_len !== LEN_W'(2)) begin mismatched++; $display("[TB] FAIL mid_next_desc: got addr=%0d len=%0d expected addr=0 len=2", bus.desc_addr, bus.desc_len); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_wrap();
    test_full_drop();
    test_oversize();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
